demux1to2_32_buf: RTL and testbench

//  Buffered 1-to-2 demultiplexer; the splitting counterpart of the 2-to-1 word mux.
//  A single valid/ready word stream is steered by sel to output branch A (sel=0) or B (sel=1).

---
 rtl/demux1to2_32_buf.sv | 111 +++++++++++
 tb/tb_demux1to2_32_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_32_buf.sv
// Buffered 1-to-2 word demultiplexer: sel steers a valid/ready stream into one of two
// independent per-branch FIFOs, so a stalled consumer only blocks its own branch.
module demux1to2_32_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = PW + 1;
    localparam int unsigned NB = 2;

    // Branch index 0 is A, 1 is B.
    logic [WIDTH-1:0] mem_q    [NB][DEPTH];
    logic [WIDTH-1:0] mem_d    [NB][DEPTH];
    logic [PW-1:0]    wr_ptr_q [NB];
    logic [PW-1:0]    wr_ptr_d [NB];
    logic [PW-1:0]    rd_ptr_q [NB];
    logic [PW-1:0]    rd_ptr_d [NB];
    logic [OW-1:0]    occ_q    [NB];
    logic [OW-1:0]    occ_d    [NB];
    logic [15:0]      cnt_q    [NB];
    logic [15:0]      cnt_d    [NB];

    logic [NB-1:0]    full;
    logic [NB-1:0]    push;
    logic [NB-1:0]    pop;
    logic [NB-1:0]    out_ready;

    assign out_ready = {b_ready, a_ready};

    // Handshake decode; in_ready looks only at the selected branch's full flag.
    always_comb begin
        full = '0;
        push = '0;
        pop  = '0;
        for (int b = 0; b < NB; b++) begin
            full[b] = (occ_q[b] == OW'(DEPTH));
            pop[b]  = (occ_q[b] != '0) && out_ready[b];
        end
        in_ready = sel ? !full[1] : !full[0];
        push[0]  = in_valid && !sel && !full[0];
        push[1]  = in_valid &&  sel && !full[1];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        for (int b = 0; b < NB; b++) begin
            if (push[b]) begin
                mem_d[b][wr_ptr_q[b]] = in_data;
                wr_ptr_d[b]           = wr_ptr_q[b] + PW'(1);
                cnt_d[b]              = cnt_q[b] + 16'd1;
            end
            if (pop[b]) begin
                rd_ptr_d[b] = rd_ptr_q[b] + PW'(1);
            end
            case ({push[b], pop[b]})
                2'b10:   occ_d[b] = occ_q[b] + OW'(1);
                2'b01:   occ_d[b] = occ_q[b] - OW'(1);
                default: occ_d[b] = occ_q[b];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[b][i] <= '0;
                end
                wr_ptr_q[b] <= '0;
                rd_ptr_q[b] <= '0;
                occ_q[b]    <= '0;
                cnt_q[b]    <= '0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head words come straight from storage; stale entries show while a branch is empty.
    assign a_data  = mem_q[0][rd_ptr_q[0]];
    assign b_data  = mem_q[1][rd_ptr_q[1]];
    assign a_valid = (occ_q[0] != '0);
    assign b_valid = (occ_q[1] != '0);
    assign cnt_a   = cnt_q[0];
    assign cnt_b   = cnt_q[1];

endmodule

// File: tb/tb_demux1to2_32_buf.sv
// Bench for demux1to2_32_buf: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_demux1to2_32_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready = 1'b0;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready = 1'b0;
    logic [15:0]      cnt_a;
    logic [15:0]      cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    demux1to2_32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per branch, plain acceptance counters.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [15:0]      m_cnt_a = '0;
    logic [15:0]      m_cnt_b = '0;
    bit               seen_a = 1'b0;
    bit               seen_b = 1'b0;

    function automatic logic model_ready(input logic s);
        return s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            m_cnt_a <= '0;
            m_cnt_b <= '0;
            seen_a  <= 1'b0;
            seen_b  <= 1'b0;
        end else begin
            logic acc;
            acc = in_valid && model_ready(sel);
            if (a_ready && qa.size() != 0) void'(qa.pop_front());
            if (b_ready && qb.size() != 0) void'(qb.pop_front());
            if (acc) begin
                if (sel) begin
                    qb.push_back(in_data);
                    m_cnt_b <= m_cnt_b + 16'd1;
                    seen_b  <= 1'b1;
                end else begin
                    qa.push_back(in_data);
                    m_cnt_a <= m_cnt_a + 16'd1;
                    seen_a  <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        check("m_in_ready", in_ready, model_ready(sel));
        check("m_a_valid", a_valid, qa.size() != 0);
        check("m_b_valid", b_valid, qb.size() != 0);
        if (qa.size() != 0)  check("m_a_data", a_data, qa[0]);
        else if (!seen_a)    check("m_a_data_rst", a_data, 32'h0);
        if (qb.size() != 0)  check("m_b_data", b_data, qb[0]);
        else if (!seen_b)    check("m_b_data_rst", b_data, 32'h0);
        check("m_cnt_a", cnt_a, m_cnt_a);
        check("m_cnt_b", cnt_b, m_cnt_b);
    end

    task automatic set_in(input logic v, input logic s, input logic [31:0] d,
                          input logic ar, input logic br);
        in_valid = v;
        sel      = s;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] d,
                        input logic ar, input logic br);
        set_in(v, s, d, ar, br);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_cnt_a", cnt_a, 16'h0);

        // Mid-stream asynchronous reset with both branches holding words.
        step(1'b1, 1'b0, 32'hC0DE0001, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hC0DE0002, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hC0DE0003, 1'b0, 1'b0);
        check("pre_rst_cnt_a", cnt_a, 16'd2);
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("arst_a_valid", a_valid, 1'b0);
        check("arst_b_valid", b_valid, 1'b0);
        check("arst_cnt_a", cnt_a, 16'h0);
        check("arst_cnt_b", cnt_b, 16'h0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_a_data", a_data, 32'h0);
        check("arst_b_data", b_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single push to A, visible one cycle later.
        step(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
        check("t2_a_valid", a_valid, 1'b1);
        check("t2_a_data", a_data, 32'h11111111);
        check("t2_b_valid", b_valid, 1'b0);
        check("t2_cnt_a", cnt_a, 16'd1);
        check("t2_cnt_b", cnt_b, 16'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Fill A, refuse a third A word, B still accepts.
        step(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
        set_in(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
        #1 check("t3_full_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1 check("t3_refused_cnt_a", cnt_a, 16'd3);
        check("t3_head_a", a_data, 32'hA0);
        set_in(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
        #1 check("t3_b_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 check("t3_b_valid", b_valid, 1'b1);
        check("t3_b_data", b_data, 32'hB0);

        // Full A with simultaneous pop: push refused this cycle, accepted the next.
        set_in(1'b1, 1'b0, 32'hA2, 1'b1, 1'b0);
        #1 check("t4_in_ready0", in_ready, 1'b0);
        @(posedge clk);
        #1 check("t4_head_a", a_data, 32'hA1);
        check("t4_cnt_a", cnt_a, 16'd3);
        check("t4_in_ready1", in_ready, 1'b1);
        @(posedge clk);
        #1 check("t4_push_a", a_data, 32'hA2);
        check("t4_cnt_a2", cnt_a, 16'd4);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Alternating stream at full throughput after a fresh reset.
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, logic'(i % 2), 32'(i), 1'b1, 1'b1);
            #1 check("t5_in_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            if (i % 2 == 0) begin
                check("t5_a_valid", a_valid, 1'b1);
                check("t5_a_data", a_data, 32'(i));
            end else begin
                check("t5_b_valid", b_valid, 1'b1);
                check("t5_b_data", b_data, 32'(i));
            end
        end
        check("t5_cnt_a", cnt_a, 16'd5);
        check("t5_cnt_b", cnt_b, 16'd5);

        // Drive cnt_b up to 0xFFFF, then one more push wraps it.
        for (int k = 0; k < 70000 && m_cnt_b != 16'hFFFF; k++) begin
            step(1'b1, 1'b1, 32'(k), 1'b0, 1'b1);
        end
        check("t6_cnt_b_max", cnt_b, 16'hFFFF);
        step(1'b1, 1'b1, 32'hFEED, 1'b0, 1'b1);
        check("t6_cnt_b_wrap", cnt_b, 16'h0000);
        check("t6_cnt_a_kept", cnt_a, 16'd5);
        check("t6_b_data", b_data, 32'hFEED);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
